riscv_muldiv_unit: RTL and testbench
====================================

# riscv_muldiv_unit

Iterative RV32M/RV64M multiply/divide unit that sits beside the ALU in the EXE stage of the five-stage pipeline. It accepts one M-extension operation at a time, computes it over multiple cycles with a shift-add multiplier and a restoring divider, and drives `busy` so the hazard logic can freeze PC, IF_ID and ID_EXE. It generalises the single-cycle ALU path in operand width, and adds a multi-cycle handshake, flush support and RISC-V-exact corner-case results.

## Interface
- `XLEN`, default 32: operand and result width. Legal values are 32 and 64.
- `FAST_MUL`, default 0: when 1, all MUL* ops complete in one cycle using a combinational multiplier; when 0, they are iterative.
- `clk` input, 1: clock. All state changes on the rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `start` input, 1: request a new operation. Sampled only while `ready`=1.
- `func3` input, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` input, XLEN: rs1 operand, already forwarded.
- `b` input, XLEN: rs2 operand, already forwarded.
- `rd_in` input, 5: destination register tag, carried with the operation.
- `flush` input, 1: synchronous kill of any in-flight operation.
- `ready` output, 1: high when the unit can accept `start` this cycle.
- `busy` output, 1: pipeline stall request.
- `done` output, 1: one-cycle pulse; `result` and `rd_out` are valid in that cycle.
- `result` output, XLEN: operation result.
- `rd_out` output, 5: tag of the completed operation.

## Operation
- FSM states are IDLE, CALC and DONE.
- **IDLE**: `ready`=1, `busy`=0. When `start` is seen, latch `func3` and `rd_in`, latch |a| and |b| per signedness, latch the result sign, clear the counter, and go to CALC.
- **Signedness**:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats `a` as signed and `b` as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
- **Result sign**:
  - Multiply: sign(a) XOR sign(b).
  - DIV: sign(a) XOR sign(b).
  - REM: sign(a).
- **Shortcuts**: the following go from IDLE directly to DONE (latency 1), with `result` registered on the same edge:
  - Divide by zero (b=0): DIV/DIVU give all ones; REM/REMU give `a` unmodified.
  - Signed overflow (DIV/REM with a=most-negative and b=all ones): DIV gives `a`; REM gives 0.
  - FAST_MUL=1 with any MUL* op: the 2·XLEN-bit product is computed combinationally.
- **CALC**: one iteration per cycle, with a counter of width clog2(XLEN)+1.
  - Multiply: 2·XLEN-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring algorithm, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
  - After XLEN iterations, apply the sign correction (two's-complement negate) and go to DONE.
- **Result selection**: MUL takes product[XLEN-1:0]; MULH, MULHSU and MULHU take product[2·XLEN-1:XLEN], negated across the full 2·XLEN width before the slice.
- **DONE**:
  - `done`=1, `busy`=0, `ready`=1.
  - `start` in DONE is accepted exactly as in IDLE, which allows back-to-back operations.
  - Otherwise go to IDLE.
- **Status outputs**:
  - `busy` = (state==CALC).
  - `ready` = (state!=CALC).
- **flush**: in any state, forces IDLE on the next edge and suppresses `done`. `flush` and `start` in the same cycle means flush wins and the start is dropped.
- **Hold behaviour**: `result` and `rd_out` hold their last completed values until the next DONE.

## Timing
- **Reset** (asynchronous, any state, including mid-CALC):
  - State becomes IDLE.
  - `done`=0, `busy`=0, `ready`=1.
  - `result`=0, `rd_out`=0, counter=0, operand and accumulator registers cleared.
- **Iterative latency**: `start` sampled at the edge ending cycle T gives CALC in cycles T+1 … T+XLEN and `done` in cycle T+XLEN+1. That is 33 cycles for XLEN=32 and 65 for XLEN=64.
- **Shortcut latency**: `done` in cycle T+1, and `busy` is never asserted.
- **Operand capture**: `a`, `b` and `func3` are captured at the start edge only; later changes on them have no effect.
- **Throughput**: one iterative operation per XLEN+1 cycles; one shortcut operation per cycle.

## Test plan
- **MUL, MULHU**, XLEN=32, FAST_MUL=0:
  - MUL a=7, b=0xFFFFFFFD gives `result`=0xFFFFFFEB, and `done` exactly 33 cycles after `start`.
  - MULHU a=b=0xFFFFFFFF gives 0xFFFFFFFE.
- **MULH, MULHSU**:
  - MULH a=b=0x80000000 gives 0x40000000.
  - MULHSU a=0xFFFFFFFF, b=2 gives 0xFFFFFFFF.
  - Repeat with FAST_MUL=1: same values, `done` at T+1, `busy` stays 0.
- **DIV/REM** a=0xFFFFFFF9 (−7), b=2: DIV gives 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU gives 0x7FFFFFFC.
- **Corner cases**, each with `done` at T+1:
  - DIVU 100/0 gives 0xFFFFFFFF; REMU 100/0 gives 100.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0.
- **Flush and reset**:
  - `flush` at CALC cycle 10 means no `done`, IDLE next cycle, and a new DIV then completes correctly.
  - `rst` pulsed mid-CALC immediately forces all outputs to their reset values.
- **Back-to-back**: `start` held high across DONE starts the second op in the DONE cycle; its `done` arrives 33 cycles later with `rd_out` = the second tag (e.g. 5 then 9).

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EXE stage: shift-add multiplier,
// restoring divider, single-cycle shortcuts for divide corner cases and optional fast multiply.
module riscv_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [1:0]      dbg_state
);

  // Handshake: an op is taken on a rising edge when start=1, ready=1 and flush=0;
  // done is a one-cycle pulse with result/rd_out valid and has no backpressure.
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic              accept, last;
  logic              in_is_mul, in_signed_a, in_signed_b, a_neg, b_neg, res_neg;
  logic              div_zero, div_ovf, shortcut;
  logic [XLEN-1:0]   mag_a, mag_b, sc_result;
  logic [2*XLEN-1:0] fast_prod;

  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] opa, acc;
  logic [XLEN-1:0]   opb, rem_q;

  logic [2*XLEN-1:0] acc_nx, mul_fin;
  logic [XLEN:0]     shifted;
  logic              q_bit;
  logic [XLEN-1:0]   rem_nx, quo_nx, rem_fin, quo_fin, calc_result;

  assign accept = start && (state != S_CALC) && !flush;
  assign last   = (cnt == CW'(XLEN - 1));

  // Decode of the incoming request
  always_comb begin
    in_is_mul   = !func3[2];
    in_signed_a = (func3 != 3'b011) && (func3 != 3'b101) && (func3 != 3'b111);
    in_signed_b = in_signed_a && (func3 != 3'b010);
    a_neg       = in_signed_a && a[XLEN-1];
    b_neg       = in_signed_b && b[XLEN-1];
    mag_a       = a_neg ? -a : a;
    mag_b       = b_neg ? -b : b;
    res_neg     = (func3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
    div_zero    = func3[2] && (b == '0);
    div_ovf     = func3[2] && !func3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    shortcut    = div_zero || div_ovf || (FAST_MUL && in_is_mul);
    if (div_zero)            sc_result = func3[1] ? a : '1;
    else if (div_ovf)        sc_result = func3[1] ? '0 : a;
    else if (func3 == 3'b000) sc_result = fast_prod[XLEN-1:0];
    else                     sc_result = fast_prod[2*XLEN-1:XLEN];
  end

  if (FAST_MUL) begin : g_fast
    logic [2*XLEN-1:0] ext_a, ext_b;
    assign ext_a     = {{XLEN{a_neg}}, a};
    assign ext_b     = {{XLEN{b_neg}}, b};
    assign fast_prod = ext_a * ext_b;
  end else begin : g_slow
    assign fast_prod = '0;
  end

  // One iteration of either datapath plus the sign-corrected final result
  always_comb begin
    acc_nx  = opb[0] ? (acc + opa) : acc;
    shifted = {rem_q, opa[XLEN-1]};
    q_bit   = (shifted >= {1'b0, opb});
    rem_nx  = q_bit ? (shifted[XLEN-1:0] - opb) : shifted[XLEN-1:0];
    quo_nx  = {opa[XLEN-2:0], q_bit};
    mul_fin = neg_q ? -acc_nx : acc_nx;
    quo_fin = neg_q ? -quo_nx : quo_nx;
    rem_fin = neg_q ? -rem_nx : rem_nx;
    if (op_q == 3'b000)  calc_result = mul_fin[XLEN-1:0];
    else if (!op_q[2])   calc_result = mul_fin[2*XLEN-1:XLEN];
    else if (op_q[1])    calc_result = rem_fin;
    else                 calc_result = quo_fin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: state_nx = accept ? (shortcut ? S_DONE : S_CALC) : S_IDLE;
        S_CALC:         if (last) state_nx = S_DONE;
        default:        state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == S_CALC);
    ready     = (state != S_CALC);
    done      = (state == S_DONE);
    dbg_state = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      rem_q  <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (accept) begin
      op_q  <= func3;
      rd_q  <= rd_in;
      neg_q <= res_neg;
      cnt   <= '0;
      opa   <= {{XLEN{1'b0}}, mag_a};
      opb   <= mag_b;
      acc   <= '0;
      rem_q <= '0;
      if (shortcut) begin
        result <= sc_result;
        rd_out <= rd_in;
      end
    end else if (state == S_CALC && !flush) begin
      cnt <= cnt + CW'(1);
      if (op_q[2]) begin
        rem_q <= rem_nx;
        opa   <= {{XLEN{1'b0}}, quo_nx};
      end else begin
        acc <= acc_nx;
        opa <= {opa[2*XLEN-2:0], 1'b0};
        opb <= {1'b0, opb[XLEN-1:1]};
      end
      if (last) begin
        result <= calc_result;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Randomised and directed bench for riscv_muldiv_unit (XLEN=32), iterative and fast-multiply builds,
// checked against a plain-arithmetic RV32M reference model.
module tb_riscv_muldiv_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk, rst, flush, start0, start1, sel;
  logic [2:0]   func3;
  logic [W-1:0] a, b;
  logic [4:0]   rd_in;
  logic         ready0, busy0, done0, ready1, busy1, done1;
  logic [W-1:0] result0, result1;
  logic [4:0]   rd_out0, rd_out1;
  logic [1:0]   dbg0, dbg1;

  logic         ready_s, busy_s, done_s;
  logic [W-1:0] result_s;
  logic [4:0]   rd_out_s;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];
  logic [4:0]   rd_q[$];
  int           lat_q[$];
  logic [W-1:0] last_result;

  riscv_muldiv_unit #(.XLEN(W), .FAST_MUL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .func3(func3), .a(a), .b(b), .rd_in(rd_in),
    .flush(flush), .ready(ready0), .busy(busy0), .done(done0), .result(result0),
    .rd_out(rd_out0), .dbg_state(dbg0));

  riscv_muldiv_unit #(.XLEN(W), .FAST_MUL(1'b1)) u_fast (
    .clk(clk), .rst(rst), .start(start1), .func3(func3), .a(a), .b(b), .rd_in(rd_in),
    .flush(flush), .ready(ready1), .busy(busy1), .done(done1), .result(result1),
    .rd_out(rd_out1), .dbg_state(dbg1));

  assign ready_s  = sel ? ready1  : ready0;
  assign busy_s   = sel ? busy1   : busy0;
  assign done_s   = sel ? done1   : done0;
  assign result_s = sel ? result1 : result0;
  assign rd_out_s = sel ? rd_out1 : rd_out0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RV32M reference built from 64-bit integer arithmetic
  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (f)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return '1;
        if (x == MIN && y == '1) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin if (y == 0) return '1; return x / y; end
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN && y == '1) return '0;
        p = sx % sy; return p[31:0];
      end
      default: begin if (y == 0) return x; return x % y; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y, input bit fast);
    if (f[2] && y == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && x == MIN && y == '1) return 1;
    if (!f[2] && fast) return 1;
    return W + 1;
  endfunction

  // driver tasks
  task automatic issue(input bit s, input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y, input logic [4:0] rd);
    sel = s;
    check("ready_at_issue", ready_s, 1);
    func3 = f; a = x; b = y; rd_in = rd;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    exp_q.push_back(model(f, x, y));
    rd_q.push_back(rd);
    lat_q.push_back(model_lat(f, x, y, s));
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int offset);
    int n = 0;
    bit got = 0;
    bit saw_busy = 0;
    logic [W-1:0] e;
    logic [4:0] er;
    int el;
    e = exp_q.pop_front(); er = rd_q.pop_front(); el = lat_q.pop_front();
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clk);
      if (busy_s) saw_busy = 1;
      if (done_s) begin got = 1; n = i + offset; end
    end
    check("done_seen", got, 1);
    if (got) begin
      check("latency", n, el);
      check("result", result_s, e);
      check("rd_out", rd_out_s, er);
      if (el == 1) check("no_busy_shortcut", saw_busy, 0);
      @(negedge clk);
      check("done_pulse", done_s, 0);
      check("result_hold", result_s, e);
      last_result = e;
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return MIN;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic       t_s[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [2:0] t_f[16] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd3, 3'd1, 3'd2,
                          3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6, 3'd7};
  logic [W-1:0] t_a[16] = '{32'd7, 32'hFFFFFFFF, MIN, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, MIN, 32'hFFFFFFFF,
                            32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, MIN, MIN, 32'd23};
  logic [W-1:0] t_b[16] = '{32'hFFFFFFFD, 32'hFFFFFFFF, MIN, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, MIN, 32'd2,
                            32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};

  initial begin
    int saw;
    rst = 1'b1; flush = 1'b0; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
    func3 = '0; a = '0; b = '0; rd_in = '0; last_result = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_result", result0, 0);
    check("rst_rd_out", rd_out0, 0);
    check("rst_fast_ready", ready1, 1);
    @(posedge clk); #1 rst = 1'b0;

    // directed cases
    for (int i = 0; i < 16; i++) begin
      issue(t_s[i], t_f[i], t_a[i], t_b[i], 5'(i + 1));
      wait_done(0);
    end

    // back-to-back with start held across DONE; op1 operands change mid-flight
    issue(0, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    func3 = 3'd4; a = 32'd1000; b = 32'd7; rd_in = 5'd9; start0 = 1'b1;
    exp_q.push_back(model(3'd4, 32'd1000, 32'd7)); rd_q.push_back(5'd9); lat_q.push_back(W + 1);
    wait_done(0);
    start0 = 1'b0;
    wait_done(1);

    // flush at CALC cycle 10
    issue(0, 3'd4, 32'd5000, 32'd3, 5'd12);
    void'(exp_q.pop_back()); void'(rd_q.pop_back()); void'(lat_q.pop_back());
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy0, 0);
    check("flush_ready", ready0, 1);
    saw = 0;
    repeat (40) begin @(negedge clk); if (done0) saw = 1; end
    check("flush_no_done", saw, 0);
    check("flush_hold", result0, last_result);
    issue(0, 3'd4, 32'hFFFFFC18, 32'd7, 5'd13);
    wait_done(0);

    // flush and start together: flush wins
    func3 = 3'd5; a = 32'd77; b = 32'd3; rd_in = 5'd2; start0 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_wins_busy", busy0, 0);
    check("flush_wins_done", done0, 0);

    // asynchronous reset mid-CALC
    issue(0, 3'd3, 32'hDEADBEEF, 32'h12345678, 5'd21);
    void'(exp_q.pop_back()); void'(rd_q.pop_back()); void'(lat_q.pop_back());
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("arst_result", result0, 0);
    check("arst_rd_out", rd_out0, 0);
    check("arst_busy", busy0, 0);
    check("arst_ready", ready0, 1);
    check("arst_done", done0, 0);
    @(posedge clk); #1 rst = 1'b0;

    // randomised operations on both builds
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)));
      wait_done(0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
